ifetch_unit: RTL and testbench
==============================

// Module: ifetch_unit
// PURPOSE
//   Instruction-fetch stage; drives IFID_Reg inputs (nextInstrAddr, instr, flush).
//   Owns PC; fetches via req/ack imem port with variable latency (cache hit/miss).
//   Honors hazard-unit hold and ID-stage branch redirect.
//   Buffers data returned during hold; drains stale misses after a redirect.
// PARAMETERS
//   RESET_PC  32'h00000000  PC value loaded on reset
// PORTS
//   clk_i            in   1   clock, rising edge
//   rst_i            in   1   reset, synchronous, active-high
//   stallHold_i      in   1   hazard hold; same signal drives IFID_Reg stallHold_i
//   branchTaken_i    in   1   ID-stage taken branch/jump; redirect request
//   branchTarget_i   in   32  redirect target, valid with branchTaken_i
//   imemReq_o        out  1   imem request; held with stable addr until ack
//   imemAddr_o       out  32  imem address
//   imemAck_i        in   1   data valid; may assert in request cycle (hit)
//   imemData_i       in   32  instruction word, valid with imemAck_i
//   nextInstrAddr_o  out  32  PC+4 of issued instr -> IFID nextInstrAddr_i
//   instr_o          out  32  issued instr; 0 when no valid instr
//   flush_o          out  1   bubble request -> IFID flush_i
//   pc_o             out  32  current PC (debug)
// BEHAVIOUR
//   State: pc(32), bufInstr(32), savedTarget(32), st in {RUN,BUF,DRAIN}.
//   Reset (rst_i=1 at edge): pc<=RESET_PC, st<=RUN, bufInstr<=0, savedTarget<=0.
//     While rst_i=1: imemReq_o=0, flush_o=1, instr_o=0. Abandoned miss is legal.
//   Outputs combinational from state + inputs; nextInstrAddr_o=pc+4 (mod 2^32).
//   imemAddr_o=pc always. Ack with imemReq_o=0 is ignored.
//   RUN: imemReq_o=1.
//     br&!hold&ack   : pc<=branchTarget_i; data discarded; flush_o=1; stay RUN.
//     br&!hold&!ack  : savedTarget<=branchTarget_i; flush_o=1; ->DRAIN.
//     hold&ack       : bufInstr<=imemData_i; pc holds; ->BUF.
//     hold&!ack      : pc holds; stay RUN.
//     !hold&ack      : instr_o=imemData_i, flush_o=0; pc<=pc+4.
//     !hold&!ack     : flush_o=1 (miss bubble); pc holds.
//   BUF: imemReq_o=0.
//     br&!hold       : pc<=branchTarget_i; buffer dropped; flush_o=1; ->RUN.
//     hold           : stay BUF.
//     else           : instr_o=bufInstr, flush_o=0; pc<=pc+4; ->RUN.
//   DRAIN: imemReq_o=1 at stale pc; flush_o=1; instr_o=0.
//     ack            : pc<=savedTarget; ->RUN (next cycle requests target).
//     br&!hold       : savedTarget<=branchTarget_i (latest wins).
//   Priority: hold masks redirect (matches IFID_Reg hold>flush); redirect
//     is re-presented by ID after hold clears.
//   flush_o under hold: don't-care for IFID (hold wins); drive per table.
//   Issued instr appears in IFID outputs one cycle after the ack/BUF cycle.
//   PC wrap 32'hFFFFFFFC+4 -> 0; no alignment check.
// STRUCTURE
//   Shared pipeline package: FETCH_RUN/BUF/DRAIN 2-bit localparams; NOP_INSTR=0.
//   No sub-module; PC, skid buffer and FSM are one always block + comb decode.
// TESTING
//   1 Reset, ack same cycle, 4 fetches -> imemAddr 0,4,8,C; nextInstrAddr 4,8,C,10;
//     flush_o=0.
//   2 Miss: ack 3 cycles late at pc=0x10 -> flush_o=1 x3, imemAddr stable 0x10,
//     then instr issued, pc->0x14.
//   3 Hold 2 cycles with ack in first -> BUF, imemReq_o=0, pc=0x20; release ->
//     buffered word issued, no re-request of 0x20.
//   4 Branch to 0x100 while miss pending on 0x40 -> DRAIN, req held at 0x40
//     until ack, data dropped, next req 0x100.
//   5 Branch & hold same cycle -> no redirect, pc unchanged; branch after hold
//     -> pc=target.
//   6 Reset mid-DRAIN -> next cycle req=0, pc=RESET_PC; then RUN at RESET_PC.

Source files
------------

// File: rtl/ifetch_unit_pkg.sv
// ifetch_unit_pkg: shared fetch-stage state encoding and constants
package ifetch_unit_pkg;
    typedef enum logic [1:0] {
        FETCH_RUN   = 2'd0,
        FETCH_BUF   = 2'd1,
        FETCH_DRAIN = 2'd2
    } fetch_st_e;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
endpackage

// File: rtl/ifetch_unit.sv
// ifetch_unit: PC owner with variable-latency imem fetch, hold skid buffer and redirect drain
import ifetch_unit_pkg::*;
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stallHold_i,
    input  logic        branchTaken_i,
    input  logic [31:0] branchTarget_i,
    output logic        imemReq_o,
    output logic [31:0] imemAddr_o,
    input  logic        imemAck_i,
    input  logic [31:0] imemData_i,
    output logic [31:0] nextInstrAddr_o,
    output logic [31:0] instr_o,
    output logic        flush_o,
    output logic [31:0] pc_o
);
    fetch_st_e   st;
    logic [31:0] pc, buf_instr, saved_target;
    logic        ack, redirect, issue;
    always_comb begin
        imemReq_o       = !rst_i && st != FETCH_BUF;
        ack             = imemAck_i && imemReq_o;
        redirect        = branchTaken_i && !stallHold_i;
        issue           = !rst_i && !redirect && !stallHold_i &&
                          (st == FETCH_BUF || (st == FETCH_RUN && ack));
        instr_o         = issue ? (st == FETCH_BUF ? buf_instr : imemData_i) : NOP_INSTR;
        flush_o         = !issue;
        imemAddr_o      = pc;
        pc_o            = pc;
        nextInstrAddr_o = pc + 32'd4;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc           <= RESET_PC;
            st           <= FETCH_RUN;
            buf_instr    <= NOP_INSTR;
            saved_target <= 32'h0;
        end else begin
            case (st)
                FETCH_RUN: begin
                    if (redirect && ack) begin
                        pc <= branchTarget_i;
                    end else if (redirect) begin
                        saved_target <= branchTarget_i;
                        st           <= FETCH_DRAIN;
                    end else if (stallHold_i && ack) begin
                        buf_instr <= imemData_i;
                        st        <= FETCH_BUF;
                    end else if (ack) begin
                        pc <= pc + 32'd4;
                    end
                end
                FETCH_BUF: begin
                    if (!stallHold_i) begin
                        pc <= redirect ? branchTarget_i : pc + 32'd4;
                        st <= FETCH_RUN;
                    end
                end
                FETCH_DRAIN: begin
                    // a redirect arriving with the stale ack is the newest target
                    if (ack) begin
                        pc <= redirect ? branchTarget_i : saved_target;
                        st <= FETCH_RUN;
                    end else if (redirect) begin
                        saved_target <= branchTarget_i;
                    end
                end
                default: st <= FETCH_RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed and random fetch stimulus checked against a behavioural model
module tb_ifetch_unit;
    logic        clk_i = 1'b0, rst_i = 1'b1, stallHold_i = 1'b0, branchTaken_i = 1'b0, imemAck_i = 1'b0;
    logic [31:0] branchTarget_i = '0, imemData_i = '0;
    logic        imemReq_o, flush_o;
    logic [31:0] imemAddr_o, nextInstrAddr_o, instr_o, pc_o;
    int          checks = 0, errors = 0;
    logic [31:0] m_pc, m_bufw, m_saved;
    bit          m_buf, m_drain;

    ifetch_unit dut (
        .clk_i(clk_i), .rst_i(rst_i), .stallHold_i(stallHold_i),
        .branchTaken_i(branchTaken_i), .branchTarget_i(branchTarget_i),
        .imemReq_o(imemReq_o), .imemAddr_o(imemAddr_o), .imemAck_i(imemAck_i),
        .imemData_i(imemData_i), .nextInstrAddr_o(nextInstrAddr_o),
        .instr_o(instr_o), .flush_o(flush_o), .pc_o(pc_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16] + 16'h1357} | 32'h1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        branchTaken_i = 1'($urandom);
        stallHold_i = 1'($urandom);
        imemAck_i = 1'($urandom);
        branchTarget_i = $urandom;
        imemData_i = $urandom;
        #1;
        chk("rst_req", 32'(imemReq_o), 32'd0);
        chk("rst_flush", 32'(flush_o), 32'd1);
        chk("rst_instr", instr_o, 32'd0);
        @(posedge clk_i);
        m_pc = 32'h0;
        m_buf = 1'b0;
        m_drain = 1'b0;
    endtask

    task automatic step(input bit br, input logic [31:0] tgt, input bit hold, input bit ack);
        bit          req_e, acc, iss, redir;
        logic [31:0] ins_e;
        @(negedge clk_i);
        rst_i = 1'b0;
        branchTaken_i = br;
        branchTarget_i = tgt;
        stallHold_i = hold;
        imemAck_i = ack;
        imemData_i = ack ? mem(m_pc) : $urandom;
        #1;
        req_e = !m_buf;
        acc = ack && req_e;
        redir = br && !hold;
        iss = !br && !hold && (m_buf || (!m_drain && acc));
        ins_e = iss ? (m_buf ? m_bufw : mem(m_pc)) : 32'h0;
        chk("req", 32'(imemReq_o), 32'(req_e));
        chk("addr", imemAddr_o, m_pc);
        chk("next", nextInstrAddr_o, m_pc + 32'd4);
        chk("instr", instr_o, ins_e);
        chk("pc", pc_o, m_pc);
        if (!hold) chk("flush", 32'(flush_o), 32'(!iss));
        @(posedge clk_i);
        if (m_drain) begin
            if (acc) begin
                m_pc = redir ? tgt : m_saved;
                m_drain = 1'b0;
            end else if (redir) m_saved = tgt;
        end else if (m_buf) begin
            if (!hold) begin
                m_buf = 1'b0;
                m_pc = br ? tgt : m_pc + 32'd4;
            end
        end else if (redir) begin
            if (acc) m_pc = tgt;
            else begin
                m_drain = 1'b1;
                m_saved = tgt;
            end
        end else if (hold) begin
            if (acc) begin
                m_buf = 1'b1;
                m_bufw = mem(m_pc);
            end
        end else if (acc) m_pc = m_pc + 32'd4;
    endtask

    task automatic pc_is(input string tag, input logic [31:0] exp);
        #1;
        chk(tag, pc_o, exp);
    endtask

    initial begin
        do_reset();
        do_reset();
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
        pc_is("t1_pc", 32'h10);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        pc_is("t2_pc", 32'h14);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        #1;
        chk("t3_buf_req", 32'(imemReq_o), 32'd0);
        chk("t3_buf_pc", pc_o, 32'h20);
        step(0, 0, 1, 1);
        step(0, 0, 0, 1);
        pc_is("t3_pc", 32'h24);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 1);
        step(1, 32'h100, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        pc_is("t4_pc", 32'h100);
        step(1, 32'h200, 1, 0);
        pc_is("t5_hold_pc", 32'h100);
        step(1, 32'h200, 0, 1);
        pc_is("t5_pc", 32'h200);
        step(1, 32'h300, 0, 0);
        do_reset();
        pc_is("t6_pc", 32'h0);
        step(0, 0, 0, 1);
        pc_is("t6_run_pc", 32'h4);
        step(1, 32'hFFFF_FFFC, 0, 1);
        step(0, 0, 0, 1);
        pc_is("wrap_pc", 32'h0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) == 0) do_reset();
            else step($urandom_range(99) < 20, ($urandom_range(3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC),
                      $urandom_range(99) < 25, $urandom_range(1) == 1);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
